// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one
// downstream master port, one transaction at a time, round-robin on contention.
module axi4_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  input  logic                  pIFU_ar_valid,
  input  logic [ADDR_WIDTH-1:0] pIFU_ar_addr,
  output logic                  pIFU_ar_ready,
  output logic                  pIFU_r_valid,
  output logic [DATA_WIDTH-1:0] pIFU_r_data,
  output logic [RESP_WIDTH-1:0] pIFU_r_resp,
  input  logic                  pIFU_r_ready,
  input  logic                  pLSU_ar_valid,
  input  logic [ADDR_WIDTH-1:0] pLSU_ar_addr,
  output logic                  pLSU_ar_ready,
  output logic                  pLSU_r_valid,
  output logic [DATA_WIDTH-1:0] pLSU_r_data,
  output logic [RESP_WIDTH-1:0] pLSU_r_resp,
  input  logic                  pLSU_r_ready,
  input  logic                  pLSU_aw_valid,
  input  logic [ADDR_WIDTH-1:0] pLSU_aw_addr,
  output logic                  pLSU_aw_ready,
  input  logic                  pLSU_w_valid,
  input  logic [DATA_WIDTH-1:0] pLSU_w_data,
  input  logic [MASK_WIDTH-1:0] pLSU_w_strb,
  output logic                  pLSU_w_ready,
  output logic                  pLSU_b_valid,
  output logic [RESP_WIDTH-1:0] pLSU_b_resp,
  input  logic                  pLSU_b_ready,
  output logic                  pAXI4_ar_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4_ar_addr,
  input  logic                  pAXI4_ar_ready,
  input  logic                  pAXI4_r_valid,
  input  logic [DATA_WIDTH-1:0] pAXI4_r_data,
  input  logic [RESP_WIDTH-1:0] pAXI4_r_resp,
  output logic                  pAXI4_r_ready,
  output logic                  pAXI4_aw_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4_aw_addr,
  input  logic                  pAXI4_aw_ready,
  output logic                  pAXI4_w_valid,
  output logic [DATA_WIDTH-1:0] pAXI4_w_data,
  output logic [MASK_WIDTH-1:0] pAXI4_w_strb,
  input  logic                  pAXI4_w_ready,
  input  logic                  pAXI4_b_valid,
  input  logic [RESP_WIDTH-1:0] pAXI4_b_resp,
  output logic                  pAXI4_b_ready,
  output logic [1:0]            oGrant
);

  // State encoding doubles as the oGrant code.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GNT_IFU_RD = 2'd1,
    GNT_LSU_RD = 2'd2,
    GNT_LSU_WR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;      // last winner: 0 = IFU, 1 = LSU
  logic   w_ifu_req;
  logic   w_lsu_req;
  state_t w_lsu_state;

  assign w_ifu_req   = pIFU_ar_valid;
  assign w_lsu_req   = pLSU_aw_valid | pLSU_ar_valid;
  assign w_lsu_state = pLSU_aw_valid ? GNT_LSU_WR : GNT_LSU_RD;
  assign oGrant      = r_state;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE)
        r_last <= (w_next != GNT_IFU_RD);
    end
  end

  // A handshake completes on a cycle where valid and ready are both high at the
  // rising edge; grants only release on the response handshake of the owner.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ifu_req && w_lsu_req) w_next = r_last ? GNT_IFU_RD : w_lsu_state;
        else if (w_ifu_req)         w_next = GNT_IFU_RD;
        else if (w_lsu_req)         w_next = w_lsu_state;
      end
      GNT_IFU_RD, GNT_LSU_RD: if (pAXI4_r_valid && pAXI4_r_ready) w_next = IDLE;
      GNT_LSU_WR:             if (pAXI4_b_valid && pAXI4_b_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    pIFU_ar_ready  = 1'b0;
    pIFU_r_valid   = 1'b0;
    pIFU_r_data    = '0;
    pIFU_r_resp    = '0;
    pLSU_ar_ready  = 1'b0;
    pLSU_r_valid   = 1'b0;
    pLSU_r_data    = '0;
    pLSU_r_resp    = '0;
    pLSU_aw_ready  = 1'b0;
    pLSU_w_ready   = 1'b0;
    pLSU_b_valid   = 1'b0;
    pLSU_b_resp    = '0;
    pAXI4_ar_valid = 1'b0;
    pAXI4_ar_addr  = '0;
    pAXI4_r_ready  = 1'b0;
    pAXI4_aw_valid = 1'b0;
    pAXI4_aw_addr  = '0;
    pAXI4_w_valid  = 1'b0;
    pAXI4_w_data   = '0;
    pAXI4_w_strb   = '0;
    pAXI4_b_ready  = 1'b0;
    case (r_state)
      GNT_IFU_RD: begin
        pAXI4_ar_valid = pIFU_ar_valid;
        pAXI4_ar_addr  = pIFU_ar_addr;
        pIFU_ar_ready  = pAXI4_ar_ready;
        pIFU_r_valid   = pAXI4_r_valid;
        pIFU_r_data    = pAXI4_r_data;
        pIFU_r_resp    = pAXI4_r_resp;
        pAXI4_r_ready  = pIFU_r_ready;
      end
      GNT_LSU_RD: begin
        pAXI4_ar_valid = pLSU_ar_valid;
        pAXI4_ar_addr  = pLSU_ar_addr;
        pLSU_ar_ready  = pAXI4_ar_ready;
        pLSU_r_valid   = pAXI4_r_valid;
        pLSU_r_data    = pAXI4_r_data;
        pLSU_r_resp    = pAXI4_r_resp;
        pAXI4_r_ready  = pLSU_r_ready;
      end
      GNT_LSU_WR: begin
        pAXI4_aw_valid = pLSU_aw_valid;
        pAXI4_aw_addr  = pLSU_aw_addr;
        pLSU_aw_ready  = pAXI4_aw_ready;
        pAXI4_w_valid  = pLSU_w_valid;
        pAXI4_w_data   = pLSU_w_data;
        pAXI4_w_strb   = pLSU_w_strb;
        pLSU_w_ready   = pAXI4_w_ready;
        pLSU_b_valid   = pAXI4_b_valid;
        pLSU_b_resp    = pAXI4_b_resp;
        pAXI4_b_ready  = pLSU_b_ready;
      end
      default: ;
    endcase
  end

endmodule
